// File: rtl/fir_pkg.sv
// fir_pkg: shared widths and helpers for the FIR MAC datapath
package fir_pkg;
  localparam int FIR_DATA_W = 16;
  localparam int FIR_ACC_W  = 39;
  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction
endpackage

// File: rtl/alu_mult.sv
// alu_mult: registered full-width multiplier forming the first MAC stage
module alu_mult
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter bit SIGNED = 1'b0,
  localparam int PW    = prod_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [PW-1:0]     o_prod
);
  logic [PW-1:0] w_prod;
  if (SIGNED) begin : g_s
    assign w_prod = PW'($signed(i_a)) * PW'($signed(i_b));
  end else begin : g_u
    assign w_prod = PW'(i_a) * PW'(i_b);
  end
  always_ff @(posedge clk)
    o_prod <= !rstn ? '0 : w_prod;
endmodule

// File: rtl/alu.sv
// alu: two-stage pipelined multiply-accumulate slice (X*B + sum_in)
module alu
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int ACC_W  = FIR_ACC_W,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] inputX,
  input  logic [DATA_W-1:0] inputB,
  input  logic [ACC_W-1:0]  totalSumIn,
  output logic [ACC_W-1:0]  totalSumOut
);
  localparam int PW = prod_w(DATA_W);
  if (ACC_W < PW) begin : g_bad_w
    $error("alu: ACC_W must be at least 2*DATA_W");
  end
  logic [PW-1:0]    w_prod;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] r_sum;
  alu_mult #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_mult (
    .clk    (clk),
    .rstn   (rstn),
    .i_a    (inputX),
    .i_b    (inputB),
    .o_prod (w_prod)
  );
  if (SIGNED) begin : g_sext
    assign w_ext = ACC_W'($signed(w_prod));
  end else begin : g_zext
    assign w_ext = ACC_W'(w_prod);
  end
  // sum_in is delayed one stage so it lines up with its product
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sum       <= '0;
      totalSumOut <= '0;
    end else begin
      r_sum       <= totalSumIn;
      totalSumOut <= w_ext + r_sum;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for the pipelined MAC slice
module tb_alu;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] inputX = '0;
  logic [15:0] inputB = '0;
  logic [38:0] totalSumIn = '0;
  logic [38:0] totalSumOut;
  typedef struct {
    int unsigned due;
    logic [38:0] v;
    string       tag;
  } exp_t;
  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  alu #(.DATA_W(16), .ACC_W(39), .SIGNED(1'b0)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .inputX      (inputX),
    .inputB      (inputB),
    .totalSumIn  (totalSumIn),
    .totalSumOut (totalSumOut)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [38:0] got, input logic [38:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic expect_at(input int unsigned due, input logic [38:0] v, input string tag);
    exp_t e;
    e.due = due;
    e.v   = v;
    e.tag = tag;
    q.push_back(e);
  endtask
  task automatic apply(input logic [15:0] x, input logic [15:0] b, input logic [38:0] s,
                       input string tag, input bit chk);
    logic [38:0] m;
    inputX     = x;
    inputB     = b;
    totalSumIn = s;
    m = 39'(x) * 39'(b) + s;
    if (chk) expect_at(cyc + 2, m, tag);
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    while (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check(e.tag, totalSumOut, e.v);
    end
  endtask
  initial begin
    logic [38:0] acc;
    logic [15:0] x, b;
    apply(16'h1234, 16'h5678, 39'h99, "rst_hold", 1'b0);
    expect_at(cyc + 1, '0, "rst_edge1");
    expect_at(cyc + 2, '0, "rst_edge2");
    tick();
    tick();
    apply('0, '0, '0, "idle", 1'b0);
    rstn = 1'b1;
    tick();
    tick();
    expect_at(cyc + 1, '0, "basic_not_1st");
    apply(16'd3, 16'd5, '0, "basic_2nd", 1'b1);
    tick();
    tick();
    apply(16'hFFFF, 16'hFFFF, '0, "max_prod", 1'b1);
    tick();
    apply(16'd1, 16'd1, 39'h7F_FFFF_FFFF, "wrap", 1'b1);
    tick();
    tick();
    acc = totalSumOut;
    for (int i = 0; i < 5; i++) begin
      x = 16'($urandom);
      b = 16'($urandom);
      totalSumIn = totalSumOut;
      inputX = x;
      inputB = b;
      acc = 39'(x) * 39'(b) + acc;
      expect_at(cyc + 2, acc, $sformatf("loop%0d", i));
      tick();
      tick();
    end
    for (int i = 1; i <= 8; i++) begin
      apply(16'(i), 16'd2, 39'd100, $sformatf("b2b%0d", i), 1'b1);
      tick();
    end
    apply(16'd7, 16'd9, 39'd11, "inflight", 1'b1);
    tick();
    apply(16'd4, 16'd4, 39'd4, "rst_mid", 1'b0);
    rstn = 1'b0;
    q.delete();
    expect_at(cyc + 1, '0, "rst_mid");
    tick();
    rstn = 1'b1;
    expect_at(cyc + 1, '0, "refill_1st");
    apply(16'd6, 16'd7, 39'd1, "refill_2nd", 1'b1);
    tick();
    tick();
    tick();
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: never checked, expected %0d", e.tag, e.v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- Pipelined multiply-accumulate (MAC) slice for the FIR filter datapath.
- Computes totalSumOut = inputX * inputB + totalSumIn.
- One tap per instance; slices chain by feeding one slice's totalSumOut into the next slice's totalSumIn, or by looping it back to accumulate.
- Fully pipelined: 2-cycle latency, one new operand set accepted every cycle.

Parameters:
- DATA_W, 16, width of inputX and inputB.
- ACC_W, 39, width of totalSumIn/totalSumOut; must be at least 2*DATA_W.
- SIGNED, 0, 0 = unsigned operands (default, required for FIR build); 1 = two's-complement operands with sign-extended product.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset, sampled on rising edge of clk.
- inputX  input  DATA_W  sample operand.
- inputB  input  DATA_W  coefficient operand.
- totalSumIn  input  ACC_W  incoming partial sum.
- totalSumOut  output  ACC_W  registered result.

Behaviour:
- One clock; reset is synchronous and active-low (clk, rstn). There is no asynchronous reset path.
- Stage 1, at posedge clk:
  - prod_q <= inputX * inputB, full 2*DATA_W-bit product.
  - sum_q <= totalSumIn.
- Stage 2, at posedge clk: totalSumOut <= zero/sign-extend(prod_q) + sum_q, truncated to ACC_W bits (modulo 2^ACC_W wrap).
- No saturation and no overflow flag.
- Latency: operands present before posedge N appear on totalSumOut after posedge N+1.
  - Inputs changed just after an edge are read after the second following edge.
- Throughput: 1 result per cycle. No handshake and no valid/stall; every cycle's inputs are consumed.
- Reset: while rstn=0 at a posedge, prod_q, sum_q and totalSumOut are all cleared to 0. Reset overrides all stage updates.
  - Reset mid-operation discards in-flight data. The first post-reset result appears 2 edges after rstn returns high with operands applied.
- totalSumOut is a pure register output with no combinational path from any input.
- Arithmetic, SIGNED=0: product range 0..(2^DATA_W-1)^2; the sum wraps modulo 2^ACC_W.
- Arithmetic, SIGNED=1: operands and totalSumIn are two's complement; the result wraps modulo 2^ACC_W.
- Loopback accumulation (totalSumIn driven from totalSumOut) is legal. Software must account for the 2-cycle latency when sequencing.
- Unknown/X inputs are not required to be tolerated.

Decomposition:
- Shared package fir_pkg holds:
  - constants FIR_DATA_W=16 and FIR_ACC_W=39;
  - a localparam function computing product width (2*DATA_W).
- One sub-module is natural: alu_mult.
  - Registered DATA_W x DATA_W multiplier that implements stage 1 (product register).
  - Lets synthesis retime or replace it with a DSP macro.
- The adder and output register stay in alu.

Test Plan:
- Reset: hold rstn=0 for 2 edges with nonzero inputs -> totalSumOut=0. Release rstn.
- Basic MAC: X=3, B=5, totalSumIn=0 -> totalSumOut=15 after the 2nd posedge, and not after the 1st.
- Max product: X=0xFFFF, B=0xFFFF, totalSumIn=0 -> 4294836225. Then totalSumIn=0x7F_FFFF_FFFF, X=1, B=1 -> 0 (wrap).
- Loopback chain: 5 random X/B pairs, each result fed back as totalSumIn, sampling every 2 edges -> each output equals X*B + previous output mod 2^39.
- Back-to-back: new operands every cycle (X=1..8, B=2, totalSumIn=100) -> outputs 102, 104, ..., 116 on consecutive cycles.
- Reset mid-stream: assert rstn=0 for one edge with data in flight -> totalSumOut=0 after that edge. Post-reset the pipeline refills with the correct 2-cycle latency.
